// File: rtl/branch_predict_unit.sv
// Branch resolution and bimodal prediction: Decode-side counter lookup, Execute-side
// outcome/PC-select/flush generation, table training and wrapping performance counters.
module branch_predict_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 16,
  parameter int CTR_BITS    = 2,
  parameter int PRED_MODE   = 1,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   pcD,
  input  logic [2:0]        branchD,
  output logic              predTakenD,
  input  logic [XLEN-1:0]   pcE,
  input  logic [2:0]        branchE,
  input  logic [1:0]        jumpE,
  input  logic              predTakenE,
  input  logic              zero,
  input  logic              neg,
  input  logic              ltu,
  output logic [1:0]        PCSrcE,
  output logic              flushE,
  input  logic              statClr,
  output logic [CNT_W-1:0]  branchCnt,
  output logic [CNT_W-1:0]  mispredCnt
);

  localparam int IDX = $clog2(BHT_ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((2 ** (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};

  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BLT  = 3'b011;
  localparam logic [2:0] BR_BGE  = 3'b100;
  localparam logic [2:0] BR_BLTU = 3'b101;
  localparam logic [2:0] BR_BGEU = 3'b110;

  localparam logic [1:0] JMP_JAL  = 2'b01;
  localparam logic [1:0] JMP_JALR = 2'b11;

  localparam logic [1:0] SRC_SEQ     = 2'b00;
  localparam logic [1:0] SRC_TARGET  = 2'b01;
  localparam logic [1:0] SRC_JALR    = 2'b10;
  localparam logic [1:0] SRC_RECOVER = 2'b11;

  logic [CTR_BITS-1:0] r_bht [BHT_ENTRIES];
  logic [CNT_W-1:0]    r_branch_cnt;
  logic [CNT_W-1:0]    r_mispred_cnt;

  logic [IDX-1:0]      w_idx_d;
  logic [IDX-1:0]      w_idx_e;
  logic [CTR_BITS-1:0] w_ctr_d;
  logic [CTR_BITS-1:0] w_ctr_e;
  logic [CTR_BITS-1:0] w_ctr_next;
  logic                w_cond_d;
  logic                w_cond_e;
  logic                w_taken_e;
  logic                w_mispred_e;
  logic                w_train;
  logic [1:0]          w_pc_src;
  logic                w_unused_bits;

  assign w_idx_d = pcD[IDX+1:2];
  assign w_idx_e = pcE[IDX+1:2];

  // Only the index bits of the PCs matter to the table.
  assign w_unused_bits = ^{pcD[XLEN-1:IDX+2], pcD[1:0], pcE[XLEN-1:IDX+2], pcE[1:0]};

  // Encoding 111 is reserved and behaves as no branch.
  assign w_cond_d = (branchD != 3'b000) && (branchD != 3'b111);
  assign w_cond_e = (branchE != 3'b000) && (branchE != 3'b111);

  assign w_ctr_d = r_bht[w_idx_d];
  assign w_ctr_e = r_bht[w_idx_e];

  assign predTakenD = (PRED_MODE == 1) && w_cond_d && w_ctr_d[CTR_BITS-1];

  always_comb begin
    w_taken_e = 1'b0;
    case (branchE)
      BR_BEQ:  w_taken_e = zero;
      BR_BNE:  w_taken_e = ~zero;
      BR_BLT:  w_taken_e = neg;
      BR_BGE:  w_taken_e = zero | ~neg;
      BR_BLTU: w_taken_e = ltu;
      BR_BGEU: w_taken_e = ~ltu;
      default: w_taken_e = 1'b0;
    endcase
  end

  assign w_mispred_e = w_cond_e && (w_taken_e != predTakenE);

  // A conditional branch in E owns the PC select; jump codes are ignored then.
  always_comb begin
    w_pc_src = SRC_SEQ;
    if (w_cond_e) begin
      if (w_taken_e && !predTakenE) begin
        w_pc_src = SRC_TARGET;
      end else if (!w_taken_e && predTakenE) begin
        w_pc_src = SRC_RECOVER;
      end
    end else if (jumpE == JMP_JAL) begin
      w_pc_src = SRC_TARGET;
    end else if (jumpE == JMP_JALR) begin
      w_pc_src = SRC_JALR;
    end
  end

  assign PCSrcE = w_pc_src;
  assign flushE = (w_pc_src != SRC_SEQ);

  always_comb begin
    w_ctr_next = w_ctr_e;
    if (w_taken_e) begin
      if (w_ctr_e != CTR_MAX) begin
        w_ctr_next = w_ctr_e + CTR_BITS'(1);
      end
    end else if (w_ctr_e != '0) begin
      w_ctr_next = w_ctr_e - CTR_BITS'(1);
    end
  end

  assign w_train = (PRED_MODE == 1) && w_cond_e;

  // No bypass: a Decode read of the entry being trained sees the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        r_bht[i] <= CTR_INIT;
      end
    end else if (w_train) begin
      r_bht[w_idx_e] <= w_ctr_next;
    end
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (statClr) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (w_cond_e) begin
      r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      if (w_mispred_e) begin
        r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
      end
    end
  end

  assign branchCnt  = r_branch_cnt;
  assign mispredCnt = r_mispred_cnt;

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch resolution and bimodal prediction unit for the 5-stage RISC-V pipeline. The Decode stage indexes a table of saturating counters to predict conditional branches. The Execute stage resolves the branch (BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL, JALR), emits the PC-select code and flush request, and trains the table. The unit also keeps wrapping performance counters for resolved branches and mispredictions.

## Interface
Parameters:
- XLEN, 32: PC width.
- BHT_ENTRIES, 16: counter table depth; power of two, 2..1024; IDX = log2(BHT_ENTRIES).
- CTR_BITS, 2: counter width, 1..4.
- PRED_MODE, 1: 0 = static not-taken (table ignored, never trained); 1 = bimodal.
- CNT_W, 32: performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pcD  in  XLEN  PC of instruction in Decode.
- branchD  in  3  branch type in Decode (encoding as branchE).
- predTakenD  out  1  prediction for Decode instruction (combinational).
- pcE  in  XLEN  PC of instruction in Execute.
- branchE  in  3  000 NOB, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 BLTU, 110 BGEU, 111 reserved (treated as NOB).
- jumpE  in  2  00 none, 01 JAL, 11 JALR, 10 reserved (treated as none).
- predTakenE  in  1  predTakenD carried through the D/E register.
- zero, neg, ltu  in  1  ALU flags: equal, signed less-than, unsigned less-than.
- PCSrcE  out  2  00 sequential/no action, 01 branch/JAL target, 10 JALR target, 11 recover to pcE+4.
- flushE  out  1  high when PCSrcE != 00.
- statClr  in  1  synchronous clear of performance counters.
- branchCnt  out  CNT_W  resolved conditional branches.
- mispredCnt  out  CNT_W  mispredicted conditional branches.

## Operation
- Index: idx(pc) = pc[IDX+1:2].
- predTakenD = PRED_MODE==1 and branchD in {001..110} and MSB of bht[idx(pcD)]; otherwise 0.
- Actual outcome takenE: BEQ zero; BNE ~zero; BLT neg; BGE zero | ~neg; BLTU ltu; BGEU ~ltu.
- PCSrcE priority:
  - conditional branch: takenE & ~predTakenE -> 01; ~takenE & predTakenE -> 11; otherwise 00.
  - NOB with JAL -> 01; NOB with JALR -> 10; else 00.
  - predTakenE with no conditional branch in E is ignored.
- Training, conditional branch in E only, bimodal mode:
  - taken: bht[idx(pcE)] += 1, saturating at 2^CTR_BITS-1.
  - not taken: bht[idx(pcE)] -= 1, saturating at 0.
- Counters, each on a clock edge with a conditional branch in E:
  - branchCnt += 1.
  - mispredCnt += 1 if takenE != predTakenE.
  - Both wrap modulo 2^CNT_W.
- statClr zeroes both counters and has priority over a same-cycle increment. It does not touch the table.

## Timing
- Reset (asynchronous, immediate): every bht entry = 2^(CTR_BITS-1)-1 (weakly not-taken; 01 for 2 bits); branchCnt = mispredCnt = 0. PCSrcE/flushE/predTakenD are combinational: 00/0/0 while inputs are idle.
- predTakenD, PCSrcE and flushE have zero latency (combinational from inputs and table state).
- Table write takes effect at the rising edge; there is no read-after-write bypass. A same-cycle read of idx(pcD) == idx(pcE) returns the pre-edge value.
- Reset asserted mid-operation restores the full reset state within the same cycle. Training from the in-flight Execute instruction is lost.
- Pipeline stall/bubble handling is external: the pipeline presents branchE=NOB, jumpE=00 for bubbles, so bubbles neither train the table nor count.

## Test plan
- Reset: after rst pulse, pcD=0x40, branchD=BEQ -> predTakenD=0; branchCnt=mispredCnt=0.
- Training: BEQ at pcE=0x40 with zero=1, predTakenE=0, 2 cycles -> PCSrcE=01 both cycles; bht[0] steps 01->10->11; predTakenD for pcD=0x40 becomes 1 after the first edge; mispredCnt=2, branchCnt=2.
- Recovery: after training, BEQ at 0x40 with zero=0, predTakenE=1 -> PCSrcE=11, flushE=1; counter steps 11->10; predictor still predicts taken.
- Jumps: jumpE=01 -> PCSrcE=01; jumpE=11 -> PCSrcE=10; branchCnt unchanged; table unchanged.
- Unsigned/saturation: BLTU with ltu=1, predTakenE=1 for 5 cycles -> PCSrcE=00; counter saturates at 11; 0x540 aliases 0x40 at 16 entries and shares the counter.
- Counters/mode: CNT_W=4, 17 branches -> branchCnt=1 (wrap); statClr same cycle as a branch -> 0. PRED_MODE=0: predTakenD always 0; table never changes.
